ex_mem_barrier: RTL and testbench
=================================

// Module: ex_mem_barrier
// PURPOSE
//  EX->MEM pipeline register with a valid/ready handshake on both sides; receives the EX-stage result and control bits.
//  Implemented as a 2-entry skid buffer (main + skid): full throughput, ready toward EX is registered.
//  Lets a multi-cycle data memory stall MEM without combinational ready paths back into EX/ID.
// PARAMETERS
//  DATA_WIDTH      32  width of ALU result and store data
//  REG_ADDR_WIDTH  5   width of destination register index
// PORTS
//  clk                    in   1               rising-edge clock
//  rst_n                  in   1               async active-low reset
//  flush                  in   1               sync squash of all held entries (branch mispredict/trap)
//  exValid                in   1               EX presents a beat
//  exReady                out  1               barrier accepts a beat this cycle
//  exAluResult            in   DATA_WIDTH      address / ALU result
//  exStoreData            in   DATA_WIDTH      RHS register value for stores
//  exDestRegister         in   REG_ADDR_WIDTH  writeback register index
//  exIsMemoryWrite        in   1               store
//  exShouldUseMemoryData  in   1               load (writeback selects memory data)
//  exIsRegisterWrite      in   1               writes register file
//  memValid               out  1               beat presented to MEM
//  memReady               in   1               MEM consumes beat this cycle
//  memAluResult, memStoreData, memDestRegister, memIsMemoryWrite, memShouldUseMemoryData, memIsRegisterWrite
//                         out  as ex*          registered copies of the head beat
// BEHAVIOUR
//  - Accept = exValid & exReady; consume = memValid & memReady; all state changes on posedge clk.
//  - exReady = !skidValid, driven from a flop (no comb path from memReady).
//  - States: EMPTY (no beat), ONE (main valid), FULL (main+skid valid).
//    EMPTY: accept -> ONE (beat into main).
//    ONE: accept & !consume -> FULL (beat into skid); accept & consume -> ONE (main reloaded);
//         !accept & consume -> EMPTY; else hold.
//    FULL: exReady=0; consume -> ONE (skid moves to main, skid cleared); else hold.
//  - Latency: beat accepted in cycle N appears on mem* in N+1 when the barrier was EMPTY or
//    main is consumed in N. Sustained throughput 1 beat/cycle with memReady=1.
//  - Order preserved: skid never overtakes main.
//  - While memValid & !memReady, all mem* outputs are stable.
//  - memIsMemoryWrite, memShouldUseMemoryData, memIsRegisterWrite are ANDed with memValid,
//    so an invalid slot never writes memory or the register file.
//  - flush: next state EMPTY and exReady=1 next cycle. Flush wins over a simultaneous accept
//    (incoming beat dropped) and over a simultaneous consume (consume still occurs downstream).
//  - Reset (async, any state, incl. mid-stall): EMPTY; memValid=0, all mem* outputs 0, exReady=1.
//    Release synchronous to clk; first accept is possible in the first cycle after release.
//  - Payload widths pass through unmodified; no arithmetic.
// TESTING
//  1 Reset: assert rst_n=0 mid-FULL -> memValid=0, all mem* 0, exReady=1 immediately (async).
//  2 Streaming: memReady=1, 8 beats exAluResult=0x100..0x107 back-to-back -> memAluResult 0x100..0x107
//    in consecutive cycles, 1-cycle latency, exReady stays 1.
//  3 Stall: memReady=0, send A=0xA, B=0xB -> exReady=0 after B; C held by EX; raise memReady
//    -> A, B, C in order, no loss/duplication.
//  4 Flush in FULL, with exValid=1 same cycle -> next cycle memValid=0, exReady=1, beat dropped.
//  5 Gating: hold a store (exIsMemoryWrite=1) then flush -> memIsMemoryWrite=0 the cycle after.
//  6 Random exValid/memReady 10k cycles vs. scoreboard FIFO -> order and payload match; exReady never 0 in EMPTY/ONE.

Source files
------------

// File: rtl/ex_mem_barrier.sv
// EX->MEM pipeline barrier: 2-entry skid buffer with valid/ready on both sides.
// exReady comes from a flop, so MEM stalls never reach EX/ID combinationally.
module ex_mem_barrier #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      exValid,
  output logic                      exReady,
  input  logic [DATA_WIDTH-1:0]     exAluResult,
  input  logic [DATA_WIDTH-1:0]     exStoreData,
  input  logic [REG_ADDR_WIDTH-1:0] exDestRegister,
  input  logic                      exIsMemoryWrite,
  input  logic                      exShouldUseMemoryData,
  input  logic                      exIsRegisterWrite,
  output logic                      memValid,
  input  logic                      memReady,
  output logic [DATA_WIDTH-1:0]     memAluResult,
  output logic [DATA_WIDTH-1:0]     memStoreData,
  output logic [REG_ADDR_WIDTH-1:0] memDestRegister,
  output logic                      memIsMemoryWrite,
  output logic                      memShouldUseMemoryData,
  output logic                      memIsRegisterWrite
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     aluResult;
    logic [DATA_WIDTH-1:0]     storeData;
    logic [REG_ADDR_WIDTH-1:0] destRegister;
    logic                      isMemoryWrite;
    logic                      shouldUseMemoryData;
    logic                      isRegisterWrite;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;
  beat_t  mainQ;
  beat_t  skidQ;
  beat_t  inBeat;
  logic   readyQ;
  logic   mainValid;
  logic   accept;
  logic   consume;
  logic   loadMain;
  logic   loadSkid;
  logic   moveSkid;

  assign inBeat = '{
    aluResult:           exAluResult,
    storeData:           exStoreData,
    destRegister:        exDestRegister,
    isMemoryWrite:       exIsMemoryWrite,
    shouldUseMemoryData: exShouldUseMemoryData,
    isRegisterWrite:     exIsRegisterWrite
  };

  assign mainValid = (state != EMPTY);
  assign exReady   = readyQ;
  assign accept    = exValid & readyQ;
  assign consume   = mainValid & memReady;

  always_comb begin
    stateNext = state;
    loadMain  = 1'b0;
    loadSkid  = 1'b0;
    moveSkid  = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          stateNext = ONE;
          loadMain  = 1'b1;
        end
      end
      ONE: begin
        if (accept && !consume) begin
          stateNext = FULL;
          loadSkid  = 1'b1;
        end else if (accept && consume) begin
          loadMain  = 1'b1;
        end else if (consume) begin
          stateNext = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          stateNext = ONE;
          moveSkid  = 1'b1;
        end
      end
      default: stateNext = EMPTY;
    endcase
    // Squash beats; an incoming beat in the same cycle is dropped
    if (flush) begin
      stateNext = EMPTY;
      loadMain  = 1'b0;
      loadSkid  = 1'b0;
      moveSkid  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      readyQ <= 1'b1;
    end else begin
      state  <= stateNext;
      readyQ <= (stateNext != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mainQ <= '0;
    end else if (loadMain) begin
      mainQ <= inBeat;
    end else if (moveSkid) begin
      mainQ <= skidQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skidQ <= '0;
    end else if (loadSkid) begin
      skidQ <= inBeat;
    end else if (moveSkid) begin
      skidQ <= '0;
    end
  end

  assign memValid               = mainValid;
  assign memAluResult           = mainQ.aluResult;
  assign memStoreData           = mainQ.storeData;
  assign memDestRegister        = mainQ.destRegister;
  assign memIsMemoryWrite       = mainQ.isMemoryWrite & mainValid;
  assign memShouldUseMemoryData = mainQ.shouldUseMemoryData & mainValid;
  assign memIsRegisterWrite     = mainQ.isRegisterWrite & mainValid;

endmodule

// File: tb/tb_ex_mem_barrier.sv
// Bench for ex_mem_barrier: directed tables, hand sequences, and a
// random run against a queue-based model of the buffer.
module tb_ex_mem_barrier;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        exValid;
  logic        exReady;
  logic [31:0] exAluResult;
  logic [31:0] exStoreData;
  logic [4:0]  exDestRegister;
  logic        exIsMemoryWrite;
  logic        exShouldUseMemoryData;
  logic        exIsRegisterWrite;
  logic        memValid;
  logic        memReady;
  logic [31:0] memAluResult;
  logic [31:0] memStoreData;
  logic [4:0]  memDestRegister;
  logic        memIsMemoryWrite;
  logic        memShouldUseMemoryData;
  logic        memIsRegisterWrite;

  int asserts = 0;
  int fails   = 0;

  ex_mem_barrier #(
    .DATA_WIDTH(32),
    .REG_ADDR_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .exValid(exValid),
    .exReady(exReady),
    .exAluResult(exAluResult),
    .exStoreData(exStoreData),
    .exDestRegister(exDestRegister),
    .exIsMemoryWrite(exIsMemoryWrite),
    .exShouldUseMemoryData(exShouldUseMemoryData),
    .exIsRegisterWrite(exIsRegisterWrite),
    .memValid(memValid),
    .memReady(memReady),
    .memAluResult(memAluResult),
    .memStoreData(memStoreData),
    .memDestRegister(memDestRegister),
    .memIsMemoryWrite(memIsMemoryWrite),
    .memShouldUseMemoryData(memShouldUseMemoryData),
    .memIsRegisterWrite(memIsRegisterWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        v;
    logic        r;
    logic [31:0] alu;
    logic        eValid;
    logic        eReady;
    logic [31:0] eAlu;
  } vec_t;

  vec_t tbl[10];
  logic [71:0] q[$];

  function automatic logic [71:0] dutBeat();
    return {memAluResult, memStoreData, memDestRegister,
            memIsMemoryWrite, memShouldUseMemoryData, memIsRegisterWrite};
  endfunction

  function automatic logic [71:0] inBeat();
    return {exAluResult, exStoreData, exDestRegister,
            exIsMemoryWrite, exShouldUseMemoryData, exIsRegisterWrite};
  endfunction

  task automatic chk(input string name, input logic [71:0] act,
                     input logic [71:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idleIn();
    flush                 = 1'b0;
    exValid               = 1'b0;
    exAluResult           = '0;
    exStoreData           = '0;
    exDestRegister        = '0;
    exIsMemoryWrite       = 1'b0;
    exShouldUseMemoryData = 1'b0;
    exIsRegisterWrite     = 1'b0;
    memReady              = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_memValid"}, 72'(memValid), 72'd0);
    chk({tag, "_memOut"}, dutBeat(), 72'd0);
    chk({tag, "_exReady"}, 72'(exReady), 72'd1);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'hA, 1'b1, 1'b1, 32'hA};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'hB, 1'b1, 1'b0, 32'hA};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 32'hC, 1'b1, 1'b0, 32'hA};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'hC, 1'b1, 1'b1, 32'hB};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'hC, 1'b1, 1'b1, 32'hC};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'hD, 1'b1, 1'b1, 32'hD};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 32'hE, 1'b1, 1'b0, 32'hD};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 32'hF, 1'b0, 1'b1, 32'h0};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0};

    idleIn();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("initReset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Stall then flush-in-FULL sequence from the table
    for (int i = 0; i < 10; i++) begin
      flush             = tbl[i].fl;
      exValid           = tbl[i].v;
      memReady          = tbl[i].r;
      exAluResult       = tbl[i].alu;
      exIsRegisterWrite = 1'b1;
      tick();
      chk($sformatf("tbl%0d_memValid", i), 72'(memValid), 72'(tbl[i].eValid));
      chk($sformatf("tbl%0d_exReady", i), 72'(exReady), 72'(tbl[i].eReady));
      chk($sformatf("tbl%0d_regWrite", i), 72'(memIsRegisterWrite),
          72'(tbl[i].eValid));
      if (tbl[i].eValid)
        chk($sformatf("tbl%0d_alu", i), 72'(memAluResult), 72'(tbl[i].eAlu));
    end
    idleIn();

    // Streaming with memReady held high
    for (int i = 0; i < 8; i++) begin
      exValid     = 1'b1;
      memReady    = 1'b1;
      exAluResult = 32'h100 + 32'(i);
      tick();
      chk($sformatf("stream%0d_valid", i), 72'(memValid), 72'd1);
      chk($sformatf("stream%0d_alu", i), 72'(memAluResult),
          72'(32'h100 + 32'(i)));
      chk($sformatf("stream%0d_ready", i), 72'(exReady), 72'd1);
    end
    exValid = 1'b0;
    tick();
    chk("streamDrain_valid", 72'(memValid), 72'd0);

    // Store gating across a flush
    memReady        = 1'b0;
    exValid         = 1'b1;
    exAluResult     = 32'h55;
    exIsMemoryWrite = 1'b1;
    tick();
    exValid = 1'b0;
    chk("gate_storeHeld", 72'(memIsMemoryWrite), 72'd1);
    tick();
    chk("gate_storeStable", 72'(memIsMemoryWrite), 72'd1);
    chk("gate_aluStable", 72'(memAluResult), 72'h55);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("gate_storeFlushed", 72'(memIsMemoryWrite), 72'd0);
    chk("gate_validFlushed", 72'(memValid), 72'd0);
    idleIn();

    // Random run against the queue model
    q = {};
    for (int c = 0; c < 10000; c++) begin
      bit acc;
      bit con;
      flush                 = ($urandom_range(0, 63) == 0);
      exValid               = ($urandom_range(0, 3) != 0);
      memReady              = ($urandom_range(0, 9) < 6);
      exAluResult           = $urandom;
      exStoreData           = $urandom;
      exDestRegister        = 5'($urandom);
      exIsMemoryWrite       = 1'($urandom);
      exShouldUseMemoryData = 1'($urandom);
      exIsRegisterWrite     = 1'($urandom);
      acc = exValid && (q.size() < 2);
      con = memReady && (q.size() > 0);
      if (flush) begin
        q = {};
      end else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(inBeat());
      end
      tick();
      chk("rnd_valid", 72'(memValid), 72'(q.size() > 0));
      chk("rnd_ready", 72'(exReady), 72'(q.size() < 2));
      if (q.size() > 0)
        chk("rnd_beat", dutBeat(), q[0]);
      else
        chk("rnd_ctlGated", 72'(dutBeat() & 72'h7), 72'd0);
      if (fails > 20) break;
    end
    idleIn();

    // Async reset while FULL, then accept right after release
    exValid     = 1'b1;
    exAluResult = 32'h77;
    tick();
    exAluResult = 32'h78;
    tick();
    chk("preReset_full", 72'(exReady), 72'd0);
    exValid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("asyncReset");
    @(negedge clk);
    rst_n       = 1'b1;
    exValid     = 1'b1;
    exAluResult = 32'h99;
    tick();
    exValid = 1'b0;
    chk("postRelease_valid", 72'(memValid), 72'd1);
    chk("postRelease_alu", 72'(memAluResult), 72'h99);

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
